gpio_pio_irq: RTL and testbench
===============================

GPIO_PIO_IRQ -- requirements
Module: gpio_pio_irq

Interface
REQ-001 Parameter WIDTH, default 8: number of output bits and number of input bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into the output register by reset; only bits [WIDTH-1:0] are used.
REQ-003 Parameter EDGE_TYPE, default 0: edge-capture mode; 0 = rising, 1 = falling, 2 = any edge.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  word address of the register being accessed.
REQ-007 chipselect  input  1  slave select; qualifies writes.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data; bits [31:WIDTH] SHALL be ignored.
REQ-010 readdata  output  32  read data, combinational from address; bits [31:WIDTH] SHALL read 0.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 out_port  output  WIDTH  direct output of the output register.
REQ-013 irq  output  1  active-high level interrupt.

Function
REQ-014 A write SHALL occur only when chipselect=1 and write_n=0 at a clock edge; at most one register is written per cycle.
REQ-015 Register map: 0 = DATA, 1 = OUT, 2 = IRQ_MASK, 3 = EDGE_CAP, 4 = OUTSET, 5 = OUTCLR; addresses 6-7 SHALL read 0 and ignore writes.
REQ-016 DATA read SHALL return the synchronised input (sync2); a DATA write SHALL load the output register with writedata[WIDTH-1:0].
REQ-017 OUT read SHALL return the output register; an OUT write SHALL behave as a DATA write.
REQ-018 OUTSET write SHALL OR writedata into the output register; OUTCLR write SHALL AND the output register with ~writedata; both SHALL read 0.
REQ-019 Changes to out_port SHALL appear the clock edge after the write cycle (1-cycle latency).
REQ-020 in_port SHALL pass through a two-flop synchroniser (sync1 -> sync2), followed by a delay flop prev <= sync2.
REQ-021 Per-bit edge event: rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev; the mode is selected by EDGE_TYPE.
REQ-022 An edge event SHALL set the corresponding EDGE_CAP bit; the bit SHALL remain set (sticky) until cleared.
REQ-023 An EDGE_CAP bit set by an input transition SHALL become visible on the 3rd rising clk edge after the transition meets setup at sync1.
REQ-024 An EDGE_CAP write SHALL clear each bit where writedata is 1 (write-1-to-clear); bits where writedata is 0 SHALL be unchanged.
REQ-025 If an edge event and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win.
REQ-026 IRQ_MASK SHALL be read/write, WIDTH bits wide.
REQ-027 irq SHALL equal |(EDGE_CAP & IRQ_MASK), decoded combinationally from registers with no additional latency.
REQ-028 Masking SHALL NOT block capture: EDGE_CAP bits SHALL set regardless of IRQ_MASK.

Reset
REQ-029 While reset_n=0: output register = RESET_VALUE[WIDTH-1:0]; IRQ_MASK = 0; EDGE_CAP = 0; sync1 = sync2 = prev = 0; irq = 0.
REQ-030 Reset assertion mid-operation SHALL take effect immediately and asynchronously; deassertion SHALL be used only synchronously to clk.
REQ-031 With EDGE_TYPE 0 or 2, an input held high through reset release SHALL register as an edge 3 cycles after release; this is the defined behaviour.

Verification
REQ-032 WIDTH=8, RESET_VALUE=0xA5: hold reset, then release -> out_port=0xA5, irq=0, OUT reads 0x000000A5.
REQ-033 Write DATA=0x3C, then OUTSET=0x03, then OUTCLR=0x30 -> out_port is 0x3C, 0x3F, then 0x0F, each one cycle after its write.
REQ-034 EDGE_TYPE=0, mask=0x01, in_port[0] driven 0->1 -> EDGE_CAP=0x01 on the 3rd edge and irq=1 the same cycle; a 1->0 transition SHALL NOT set it.
REQ-035 EDGE_CAP=0x01, mask=0, write EDGE_CAP=0x01 -> bit clears and irq stays 0; with mask=0x01, irq drops the cycle after the clear.
REQ-036 Edge event on bit 2 in the same cycle as a write-1-to-clear with writedata=0x04 -> EDGE_CAP[2] remains 1.
REQ-037 WIDTH=32, EDGE_TYPE=2, toggle all inputs -> EDGE_CAP=0xFFFFFFFF; access to address 6 reads 0, and a write there changes no register.

Source files
------------

// File: rtl/gpio_pio_irq_if.sv
// Register-bus bundle for the GPIO block: address, select and write strobe driven by the
// host (master) toward the GPIO (slave), read data returned by the GPIO.
interface gpio_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/gpio_pio_irq.sv
// Parallel I/O port with an output register, set/clear aliases, synchronised inputs,
// sticky per-bit edge capture and a maskable level interrupt.
module gpio_pio_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_pio_irq_if.slave    bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_OUT      = 3'd1,
    REG_IRQ_MASK = 3'd2,
    REG_EDGE_CAP = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLR   = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rdata;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // Edge detector compares the synchronised sample against the one before it.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_evt = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_evt = ~sync2 & prev;
    end else begin : g_any
      assign edge_evt = sync2 ^ prev;
    end
  endgenerate

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    out_next = out_reg;
    cap_clr  = '0;
    if (wr_en) begin
      case (bus.address)
        REG_DATA, REG_OUT: out_next = wdata;
        REG_OUTSET:        out_next = out_reg | wdata;
        REG_OUTCLR:        out_next = out_reg & ~wdata;
        REG_EDGE_CAP:      cap_clr  = wdata;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_VALUE[WIDTH-1:0];
      irq_mask <= '0;
      edge_cap <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
    end else begin
      sync1   <= in_port;
      sync2   <= sync1;
      prev    <= sync2;
      out_reg <= out_next;
      if (wr_en && bus.address == REG_IRQ_MASK) irq_mask <= wdata;
      // A new event in the same cycle as a clear keeps the bit set.
      edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      REG_DATA:     rdata[WIDTH-1:0] = sync2;
      REG_OUT:      rdata[WIDTH-1:0] = out_reg;
      REG_IRQ_MASK: rdata[WIDTH-1:0] = irq_mask;
      REG_EDGE_CAP: rdata[WIDTH-1:0] = edge_cap;
      default: ;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_reg;
  assign irq          = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_gpio_pio_irq.sv
// Self-checking bench: directed vector table, edge/clear and reset corner sequences,
// and randomized bus/input traffic against a sample-history reference model.
module tb_gpio_pio_irq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gpio_pio_irq_if bus0 ();
  gpio_pio_irq_if bus1 ();

  logic [7:0]  in0, out0;
  logic        irq0;
  logic [31:0] in1, out1;
  logic        irq1;

  gpio_pio_irq #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .out_port(out0), .irq(irq0)
  );

  gpio_pio_irq #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .out_port(out1), .irq(irq1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: register contents plus the last three input samples taken at clock edges.
  logic [7:0] m_out, m_mask, m_cap;
  logic [7:0] hist [3];

  task automatic model_reset();
    m_out  = 8'hA5;
    m_mask = 8'h00;
    m_cap  = 8'h00;
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, hist[1]};
      3'd1:    return {24'h0, m_out};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [7:0] inv);
    logic [7:0] rise, clr;
    // An input seen high two samples ago but low three samples ago is a rising edge now.
    rise = hist[1] & ~hist[2];
    clr  = 8'h00;
    if (cs && !wn) begin
      case (a)
        3'd0, 3'd1: m_out = wd[7:0];
        3'd2:       m_mask = wd[7:0];
        3'd3:       clr = wd[7:0];
        3'd4:       m_out = m_out | wd[7:0];
        3'd5:       m_out = m_out & ~wd[7:0];
        default: ;
      endcase
    end
    m_cap   = (m_cap & ~clr) | rise;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = inv;
  endtask

  // One bus cycle on dut0; starts and ends at a falling edge.
  task automatic step(input string name, input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [7:0] inv, output logic [31:0] rd);
    bus0.address    = a;
    bus0.chipselect = cs;
    bus0.write_n    = wn;
    bus0.writedata  = wd;
    in0             = inv;
    #1;
    rd = bus0.readdata;
    check({name, "_rd"}, rd, model_read(a));
    @(posedge clk);
    model_edge(a, cs, wn, wd, inv);
    @(negedge clk);
    check({name, "_out"}, {24'h0, out0}, {24'h0, m_out});
    check({name, "_irq"}, {31'h0, irq0}, {31'h0, |(m_cap & m_mask)});
  endtask

  task automatic step1(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [31:0] inv, output logic [31:0] rd);
    bus1.address    = a;
    bus1.chipselect = cs;
    bus1.write_n    = wn;
    bus1.writedata  = wd;
    in1             = inv;
    #1;
    rd = bus1.readdata;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  inv;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [31:0] rd;
    logic [7:0]  rin;

    tbl[0]  = '{3'd1, 1'b1, 1'b1, 32'h00, 8'h00, 32'hA5, 8'hA5, 1'b0};
    tbl[1]  = '{3'd0, 1'b1, 1'b0, 32'h3C, 8'h00, 32'h00, 8'h3C, 1'b0};
    tbl[2]  = '{3'd4, 1'b1, 1'b0, 32'h03, 8'h00, 32'h00, 8'h3F, 1'b0};
    tbl[3]  = '{3'd5, 1'b1, 1'b0, 32'h30, 8'h00, 32'h00, 8'h0F, 1'b0};
    tbl[4]  = '{3'd2, 1'b1, 1'b0, 32'h01, 8'h00, 32'h00, 8'h0F, 1'b0};
    tbl[5]  = '{3'd2, 1'b1, 1'b1, 32'h00, 8'h01, 32'h01, 8'h0F, 1'b0};
    tbl[6]  = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[7]  = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b1};
    tbl[8]  = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h01, 8'h0F, 1'b1};
    tbl[9]  = '{3'd3, 1'b1, 1'b0, 32'h01, 8'h00, 32'h01, 8'h0F, 1'b0};
    tbl[10] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h00, 32'h00, 8'h0F, 1'b0};
    tbl[11] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h00, 32'h00, 8'h0F, 1'b0};
    tbl[12] = '{3'd0, 1'b1, 1'b1, 32'h00, 8'h00, 32'h00, 8'h0F, 1'b0};
    tbl[13] = '{3'd2, 1'b1, 1'b0, 32'h00, 8'h01, 32'h01, 8'h0F, 1'b0};
    tbl[14] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[15] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[16] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h01, 8'h0F, 1'b0};
    tbl[17] = '{3'd3, 1'b1, 1'b0, 32'h01, 8'h01, 32'h01, 8'h0F, 1'b0};
    tbl[18] = '{3'd3, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[19] = '{3'd6, 1'b1, 1'b1, 32'h00, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[20] = '{3'd6, 1'b1, 1'b0, 32'hFF, 8'h01, 32'h00, 8'h0F, 1'b0};
    tbl[21] = '{3'd1, 1'b1, 1'b1, 32'h00, 8'h01, 32'h0F, 8'h0F, 1'b0};
    tbl[22] = '{3'd0, 1'b1, 1'b1, 32'h00, 8'h01, 32'h01, 8'h0F, 1'b0};
    tbl[23] = '{3'd0, 1'b0, 1'b0, 32'hFF, 8'h01, 32'h01, 8'h0F, 1'b0};

    // Reset with both buses idle.
    reset_n = 1'b0;
    in0 = 8'h00;
    in1 = 32'h0;
    bus0.address = 3'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = 32'h0;
    bus1.address = 3'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_out0", {24'h0, out0}, 32'hA5);
    check("rst_irq0", {31'h0, irq0}, 32'h0);
    check("rst_out1", out1, 32'h0);
    model_reset();
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd, tbl[i].inv, rd);
      check($sformatf("tbl%0d_exp_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_exp_out", i), {24'h0, out0}, {24'h0, tbl[i].exp_out});
      check($sformatf("tbl%0d_exp_irq", i), {31'h0, irq0}, {31'h0, tbl[i].exp_irq});
    end

    // Rising edge on bit 2 lands in the same cycle as a write-1-to-clear of bit 2.
    step("set_win_a", 3'd3, 1'b0, 1'b1, 32'h0, 8'h05, rd);
    step("set_win_b", 3'd3, 1'b0, 1'b1, 32'h0, 8'h05, rd);
    step("set_win_c", 3'd3, 1'b1, 1'b0, 32'h04, 8'h05, rd);
    step("set_win_d", 3'd3, 1'b1, 1'b1, 32'h0, 8'h05, rd);
    check("set_win_cap", rd, 32'h04);

    // Randomized traffic against the reference model.
    rin = 8'h05;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) rin = 8'($urandom);
      step("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, rin, rd);
    end

    // Mid-cycle asynchronous reset, then an input held high through release.
    step("pre_rst", 3'd0, 1'b1, 1'b0, 32'h5A, 8'h00, rd);
    bus0.chipselect = 1'b0;
    bus0.address    = 3'd3;
    in0             = 8'h01;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", {24'h0, out0}, 32'hA5);
    check("async_rst_irq", {31'h0, irq0}, 32'h0);
    check("async_rst_cap", bus0.readdata, 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    step("hold_a", 3'd3, 1'b1, 1'b1, 32'h0, 8'h01, rd);
    step("hold_b", 3'd3, 1'b1, 1'b1, 32'h0, 8'h01, rd);
    step("hold_c", 3'd3, 1'b1, 1'b1, 32'h0, 8'h01, rd);
    check("hold_cap_before", rd, 32'h0);
    step("hold_d", 3'd3, 1'b1, 1'b1, 32'h0, 8'h01, rd);
    check("hold_cap_after", rd, 32'h01);

    // Wide instance with any-edge capture.
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_cap_e1", rd, 32'h0);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_cap_e3", rd, 32'h0);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_cap_all", rd, 32'hFFFF_FFFF);
    step1(3'd6, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_addr6_rd", rd, 32'h0);
    step1(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd);
    step1(3'd1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_out_rd", rd, 32'h0);
    check("w32_out_port", out1, 32'h0);
    step1(3'd2, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_mask_rd", rd, 32'h0);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd);
    check("w32_cap_kept", rd, 32'hFFFF_FFFF);
    check("w32_irq_masked", {31'h0, irq1}, 32'h0);
    step1(3'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, rd);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'h0, rd);
    check("w32_cap_cleared", rd, 32'h0);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'h0, rd);
    check("w32_fall_e2", rd, 32'h0);
    step1(3'd3, 1'b1, 1'b1, 32'h0, 32'h0, rd);
    check("w32_fall_cap", rd, 32'hFFFF_FFFF);
    step1(3'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, rd);
    check("w32_irq_on", {31'h0, irq1}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
